d_master_elf2_v1: RTL and testbench

- Initiator side of the core's data-memory bus (d_req/d_dir/d_addr/d_wdata/d_ack/d_rdata).
- Accepts one command at a time from the BF execute unit: READ cell, WRITE cell, or ADD signed delta to cell (read-modify-write).
- Sequences the req/ack handshake toward the data BRAM responder and returns one result pulse per command, with a timeout guard against a stuck responder.

---
 rtl/d_master_elf2_v1_pkg.sv | 23 ++
 rtl/d_master_elf2_v1_timeout.sv | 34 +++
 rtl/d_master_elf2_v1.sv | 126 ++++++++++++
 tb/tb_d_master_elf2_v1.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_master_elf2_v1_pkg.sv
// Shared bus-direction and opcode encodings plus data-path types for the data-memory bus initiator.
// The direction and opcode macros are also used by the execute unit, so their values must not change.
`ifndef D_MASTER_ELF2_V1_DEFS
`define D_MASTER_ELF2_V1_DEFS
`define DIRECTION_READ  1'b0
`define DIRECTION_WRITE 1'b1
`define D_OP_READ       2'd0
`define D_OP_WRITE      2'd1
`define D_OP_ADD        2'd2
`endif

package d_master_elf2_v1_pkg;

    localparam int DATA_W = 8;

    typedef logic [DATA_W-1:0] data_t;

    // Cell arithmetic wraps modulo 256; a delta above 0x7F behaves as a negative step.
    function automatic data_t wrap_add(input data_t a, input data_t b);
        return a + b;
    endfunction

endpackage

// File: rtl/d_master_elf2_v1_timeout.sv
// Ack-timeout counter: counts request cycles that have no acknowledge, and flags the cycle in
// which the limit is reached. An ack in that same cycle suppresses the flag.
module d_master_timeout #(
    parameter int ack_timeout = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    input  logic ack,
    output logic expire
);

    localparam int CW = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (run && !ack) begin
            count <= count + CW'(1);
        end
    end

    generate
        if (ack_timeout == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            assign expire = run && !ack && (count == CW'(ack_timeout - 1));
        end
    endgenerate

endmodule

// File: rtl/d_master_elf2_v1.sv
// Data-memory bus initiator: runs one READ, WRITE or ADD (read-modify-write) command at a time
// over the req/ack bus and reports a single response pulse per command.
module d_master_elf2_v1
    import d_master_elf2_v1_pkg::*;
#(
    parameter int d_addr_width = 8,
    parameter int ack_timeout  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [d_addr_width-1:0] cmd_addr,
    input  logic [7:0]              cmd_data,
    output logic                    rsp_valid,
    output logic [7:0]              rsp_data,
    output logic                    rsp_zero,
    output logic                    rsp_err,
    output logic                    d_req,
    output logic                    d_dir,
    output logic [d_addr_width-1:0] d_addr,
    output logic [7:0]              d_wdata,
    input  logic                    d_ack,
    input  logic [7:0]              d_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        GAP,
        WR,
        RESP
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [1:0]              op_q;
    logic [d_addr_width-1:0] addr_q;
    data_t                   data_q;
    data_t                   result_q;
    logic                    err_q;
    logic                    bus_active;
    logic                    expire;

    assign bus_active = (state == RD) || (state == WR);

    d_master_timeout #(
        .ack_timeout(ack_timeout)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (!bus_active),
        .run   (bus_active),
        .ack   (d_ack),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (cmd_valid) next_state = (cmd_op == `D_OP_WRITE) ? WR : RD;
            RD: begin
                if (d_ack) next_state = (op_q == `D_OP_ADD) ? GAP : RESP;
                else if (expire) next_state = RESP;
            end
            GAP:  next_state = WR;
            WR:   if (d_ack || expire) next_state = RESP;
            RESP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        d_req     = bus_active;
        d_dir     = (state == WR) ? `DIRECTION_WRITE : `DIRECTION_READ;
        d_addr    = addr_q;
        d_wdata   = data_q;
    end

    // data_q holds the WRITE value, or the ADD delta until the read returns and then the new sum.
    // The response registers load from RESP, so the pulse appears as the FSM re-enters IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= `D_OP_READ;
            addr_q    <= '0;
            data_q    <= '0;
            result_q  <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= (state == RESP);
            rsp_zero  <= (state == RESP) && (result_q == '0);
            rsp_err   <= (state == RESP) && err_q;
            if (state == RESP) rsp_data <= result_q;

            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
                err_q  <= 1'b0;
            end else if (state == RD && d_ack) begin
                if (op_q == `D_OP_ADD) data_q <= wrap_add(d_rdata, data_q);
                else result_q <= d_rdata;
            end else if (state == WR && d_ack) begin
                result_q <= data_q;
            end else if (bus_active && expire) begin
                result_q <= '0;
                err_q    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d_master_elf2_v1.sv
// Scoreboard bench for d_master_elf2_v1: a BRAM-style responder, an array reference model,
// directed cases for wrap/timeout/reset, then randomized commands.
module tb_d_master_elf2_v1;

    localparam int AW        = 8;
    localparam int TIMEOUT   = 16;
    localparam bit DIR_WRITE = 1'b1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [AW-1:0] cmd_addr = '0;
    logic [7:0]    cmd_data = '0;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic          rsp_zero;
    logic          rsp_err;
    logic          d_req;
    logic          d_dir;
    logic [AW-1:0] d_addr;
    logic [7:0]    d_wdata;
    logic          d_ack = 1'b0;
    logic [7:0]    d_rdata = '0;

    always #5 clk = ~clk;

    d_master_elf2_v1 #(
        .d_addr_width(AW),
        .ack_timeout (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_data (cmd_data),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_zero (rsp_zero),
        .rsp_err  (rsp_err),
        .d_req    (d_req),
        .d_dir    (d_dir),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata)
    );

    // BRAM responder: acks in the second cycle of each request; 'stuck' silences it.
    logic [7:0] bram [256];
    bit         stuck = 1'b0;

    always @(posedge clk) begin
        if (stuck || rst) begin
            d_ack <= 1'b0;
        end else begin
            d_ack <= d_req && !d_ack;
            if (d_req && !d_ack) d_rdata <= bram[d_addr];
            if (d_req && d_ack && d_dir == DIR_WRITE) bram[d_addr] = d_wdata;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
        int         bursts;
        int         accept;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model [256];
    int         checks = 0;
    int         passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Response and bus-protocol monitor.
    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic       prev_dir = 1'b0;
    logic [7:0] prev_addr = '0;
    logic [7:0] prev_wdata = '0;
    int         bursts = 0;
    int         burst_len = 0;
    int         last_len = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            bursts    = 0;
            burst_len = 0;
        end else begin
            if (d_req && !prev_req) begin
                bursts++;
                burst_len = 0;
            end
            if (prev_req && prev_ack) begin
                checkOutput("req_low_after_ack", d_req, 0);
            end else if (prev_req && d_req) begin
                checkOutput("bus_stable_dir", d_dir, prev_dir);
                checkOutput("bus_stable_addr", d_addr, prev_addr);
                checkOutput("bus_stable_wdata", d_wdata, prev_wdata);
            end
            if (d_req) burst_len++;
            else if (prev_req) last_len = burst_len;

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_data", rsp_data, e.data);
                    checkOutput("rsp_zero", rsp_zero, (e.data == 8'h00));
                    checkOutput("rsp_err", rsp_err, e.err);
                    checkOutput("rsp_latency", cyc - e.accept, e.lat);
                    checkOutput("req_bursts", bursts, e.bursts);
                    if (e.err) checkOutput("timeout_req_len", last_len, TIMEOUT);
                end
                bursts = 0;
            end
        end
        prev_req   = d_req;
        prev_ack   = d_ack;
        prev_dir   = d_dir;
        prev_addr  = d_addr;
        prev_wdata = d_wdata;
    end

    task automatic preload(input logic [7:0] addr, input logic [7:0] value);
        bram[addr]  = value;
        model[addr] = value;
    endtask

    // Issues one command and, when tracked, pushes the reference model's expected response.
    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr,
                                 input logic [7:0] data, input bit track);
        exp_t e;
        int   budget = 0;
        @(negedge clk);
        while (!cmd_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_wait", cmd_ready, 1);
            return;
        end
        e.accept = cyc + 1;
        if (stuck) begin
            e.data   = 8'h00;
            e.err    = 1'b1;
            e.lat    = TIMEOUT + 1;
            e.bursts = 1;
        end else begin
            e.err = 1'b0;
            case (op)
                2'd1: begin
                    if (track) model[addr] = data;
                    e.data   = data;
                    e.lat    = 3;
                    e.bursts = 1;
                end
                2'd2: begin
                    if (track) model[addr] = 8'((int'(model[addr]) + int'(data)) % 256);
                    e.data   = model[addr];
                    e.lat    = 6;
                    e.bursts = 2;
                end
                default: begin
                    e.data   = model[addr];
                    e.lat    = 3;
                    e.bursts = 1;
                end
            endcase
        end
        if (track) exp_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = 8'($urandom);
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

        // Reset held with a command offered: nothing may be accepted.
        cmd_valid = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_d_req", d_req, 0);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_cmd_ready", cmd_ready, 1);
        checkOutput("reset_d_dir", d_dir, 0);
        checkOutput("reset_d_addr", d_addr, 0);
        checkOutput("reset_d_wdata", d_wdata, 0);
        checkOutput("reset_rsp_data", rsp_data, 0);
        @(negedge clk);
        checkOutput("idle_cmd_ready", cmd_ready, 1);

        preload(8'h05, 8'h3C);
        applyStimulus(2'd0, 8'h05, 8'h00, 1'b1);
        applyStimulus(2'd1, 8'h10, 8'hA5, 1'b1);
        applyStimulus(2'd0, 8'h10, 8'h00, 1'b1);
        preload(8'h20, 8'hFF);
        applyStimulus(2'd2, 8'h20, 8'h01, 1'b1);
        preload(8'h21, 8'h00);
        applyStimulus(2'd2, 8'h21, 8'hFF, 1'b1);
        applyStimulus(2'd2, 8'h21, 8'hFF, 1'b1);
        applyStimulus(2'd3, 8'h21, 8'h00, 1'b1);
        waitDrain();
        checkOutput("bram_after_add_wrap", bram[8'h20], 8'h00);

        // Stuck responder: ADD times out in the read phase, WRITE in the write phase.
        stuck = 1'b1;
        applyStimulus(2'd2, 8'h22, 8'h11, 1'b1);
        applyStimulus(2'd1, 8'h23, 8'h77, 1'b1);
        waitDrain();

        // Reset in the middle of a write that will never be acknowledged.
        applyStimulus(2'd1, 8'h24, 8'h99, 1'b0);
        repeat (4) @(negedge clk);
        checkOutput("pre_reset_in_write", {d_req, d_dir}, 2'b11);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_d_req", d_req, 0);
        checkOutput("midreset_rsp_valid", rsp_valid, 0);
        checkOutput("midreset_cmd_ready", cmd_ready, 1);
        repeat (20) @(negedge clk);
        stuck = 1'b0;

        applyStimulus(2'd0, 8'h22, 8'h00, 1'b1);
        applyStimulus(2'd0, 8'h24, 8'h00, 1'b1);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), 8'($urandom), 1'b1);
        end
        waitDrain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
